// File: rtl/sll_seq_pkg.sv
// Shared ALU definitions for the multicycle logical-left shifter.
package sll_seq_pkg;

  // Operand/result width and shift-amount width
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  // Stage counter width: counts stages SHAMT_W-1 down to 0
  localparam int unsigned CNT_W = 3;

  // First stage index (weight 2^(SHAMT_W-1) = 16)
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(SHAMT_W - 1);

  // Shifter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sll_seq_mux_2.sv
// Generic 2:1 word mux: i_sel=0 passes i_a, i_sel=1 passes i_b.
module mux_2
  import sll_seq_pkg::*;
#(
  parameter int unsigned W = WIDTH
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y_c
);

  // Select between the unshifted and shifted word
  assign o_y_c = i_sel ? i_b : i_a;

endmodule

// File: rtl/sll_seq.sv
// Multicycle 32-bit logical-left shifter: one binary-weighted stage per cycle
// (16, 8, 4, 2, 1), fixed 5-cycle latency, sticky flag for shifted-out ones.
module sll_seq
  import sll_seq_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operandA,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               lost,
  output logic               result_rdy,
  output logic               busy
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;

  logic [WIDTH-1:0]     r_work;
  logic [SHAMT_W-1:0]   r_shamt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_lost_acc;

  logic [WIDTH-1:0]     r_result;
  logic                 r_lost;
  logic                 r_rdy;
  logic                 r_busy;
  logic                 w_rdy_nxt;
  logic                 w_busy_nxt;

  logic [WIDTH-1:0]     w_shifted;
  logic                 w_discard;
  logic                 w_sel;
  logic [WIDTH-1:0]     w_work_nxt;
  logic                 w_stage_lost;

  // Per-stage shifted word and OR of the bits it pushes out of bit 31
  always_comb begin
    w_shifted = r_work;
    w_discard = 1'b0;
    case (r_cnt)
      3'd4: begin
        w_shifted = {r_work[15:0], 16'h0000};
        w_discard = |r_work[31:16];
      end
      3'd3: begin
        w_shifted = {r_work[23:0], 8'h00};
        w_discard = |r_work[31:24];
      end
      3'd2: begin
        w_shifted = {r_work[27:0], 4'h0};
        w_discard = |r_work[31:28];
      end
      3'd1: begin
        w_shifted = {r_work[29:0], 2'b00};
        w_discard = |r_work[31:30];
      end
      3'd0: begin
        w_shifted = {r_work[30:0], 1'b0};
        w_discard = r_work[31];
      end
      default: begin
        w_shifted = r_work;
        w_discard = 1'b0;
      end
    endcase
  end

  assign w_sel        = r_shamt[r_cnt];
  assign w_stage_lost = r_lost_acc | (w_sel & w_discard);

  // Stage applies only when the amount bit for this weight is set
  mux_2 #(.W(WIDTH)) u_stage_mux (
    .i_a   (r_work),
    .i_b   (w_shifted),
    .i_sel (w_sel),
    .o_y_c (w_work_nxt)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; requests are taken only in IDLE or DONE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the flags come straight off flops
  always_comb begin
    w_busy_nxt = 1'b0;
    w_rdy_nxt  = 1'b0;
    w_busy_nxt = (w_state_nxt == SHIFT);
    w_rdy_nxt  = (w_state_nxt == DONE);
  end

  // Status flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_rdy  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_rdy  <= w_rdy_nxt;
    end
  end

  // Datapath: capture on accept, one stage per SHIFT cycle, publish on last stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_work     <= '0;
      r_shamt    <= '0;
      r_cnt      <= '0;
      r_lost_acc <= 1'b0;
      r_result   <= '0;
      r_lost     <= 1'b0;
    end else if (w_accept) begin
      r_work     <= operandA;
      r_shamt    <= shamt;
      r_lost_acc <= 1'b0;
      r_cnt      <= CNT_FIRST;
    end else if (r_state == SHIFT) begin
      r_work     <= w_work_nxt;
      r_lost_acc <= w_stage_lost;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_result <= w_work_nxt;
        r_lost   <= w_stage_lost;
      end
    end
  end

  assign result     = r_result;
  assign lost       = r_lost;
  assign result_rdy = r_rdy;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sll_seq.sv
// Scoreboard bench for sll_seq: driver queues expected results, monitor
// checks value, lost flag, latency and busy width on every result_rdy.
module tb_sll_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] operandA;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        lost;
  logic        result_rdy;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        lst;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   busy_run = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  sll_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .operandA   (operandA),
    .shamt      (shamt),
    .result     (result),
    .lost       (lost),
    .result_rdy (result_rdy),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every completion against the head of the scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (result_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rdy: result_rdy high with nothing pending, result=0x%08h", result);
        end else begin
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("lost", 32'(lost), 32'(e.lst));
          check("latency", 32'(cyc - e.acc_cyc), 32'd5);
          check("busy_cycles", 32'(busy_run), 32'd5);
          check("busy_with_rdy", 32'(busy), 32'd0);
        end
        busy_run = 0;
      end
    end
  end

  // Drive a request at the current negedge; acceptance is on the next posedge
  task automatic issue(input logic [31:0] a, input logic [4:0] s,
                       input logic [31:0] er, input logic el, input bit push);
    exp_t e;
    start    = 1'b1;
    operandA = a;
    shamt    = s;
    if (push) begin
      e.res = er;
      e.lst = el;
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [4:0] s,
                        input logic [31:0] er, input logic el);
    @(negedge clock);
    issue(a, s, er, el, 1'b1);
    @(negedge clock);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    operandA = '0;
    shamt    = '0;
    repeat (2) @(negedge clock);
    check("rst_result", result, 32'h0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_rdy", 32'(result_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    run_op(32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
    run_op(32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b1);

    // Reset three stages into an operation: outputs clear, no completion
    @(negedge clock);
    issue(32'hAAAA_AAAA, 5'd8, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_result", result, 32'h0);
    check("midrst_lost", 32'(lost), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rdy", 32'(result_rdy), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    issue(32'hAAAA_AAAA, 5'd8, 32'hAAAA_AA00, 1'b1, 1'b1);
    @(negedge clock);
    start = 1'b0;
    wait_drain();

    // Start held through SHIFT is ignored; a start in DONE chains back-to-back
    @(negedge clock);
    issue(32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      issue(32'hDEAD_BEEF, 5'd3, 32'h0, 1'b0, 1'b0);
    end
    @(negedge clock);
    issue(32'h8000_0000, 5'd1, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    issue(32'h8000_0000, 5'd1, 32'h0000_0000, 1'b1, 1'b1);
    @(negedge clock);
    start = 1'b0;
    wait_drain();

    run_op(32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1);
    run_op(32'hF0F0_F0F0, 5'd5,  32'h1E1E_1E00, 1'b1);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
